// File: rtl/wb_output_bank.sv
// Bank of NUM_REGS wishbone-addressed output registers with write/set/clear/toggle
// lane operations and a self-clearing timed-pulse mode.
module wb_output_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int SELECT_WIDTH = 4,
   parameter int NUM_REGS = 4,
   parameter int ADDR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PAT = '0,
   parameter int PULSE_LEN = 16
) (
   input  logic                           clk_i,
   input  logic                           reset_n,
   input  logic                           cyc_i,
   input  logic                           stb_i,
   input  logic                           we_i,
   input  logic [ADDR_WIDTH-1:0]          adr_i,
   input  logic [SELECT_WIDTH-1:0]        sel_i,
   input  logic [DATA_WIDTH-1:0]          dat_i,
   output logic [DATA_WIDTH-1:0]          dat_o,
   output logic                           ack_o,
   output logic                           err_o,
   output logic                           rty_o,
   output logic [NUM_REGS*DATA_WIDTH-1:0] out
);

   localparam int SB = $clog2(SELECT_WIDTH);
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam int GW = DATA_WIDTH / SELECT_WIDTH;
   localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN - 1);
   localparam logic [IW:0] REG_LIMIT = (IW+1)'(NUM_REGS);

   localparam logic [2:0] MODE_WRITE  = 3'd0;
   localparam logic [2:0] MODE_SET    = 3'd1;
   localparam logic [2:0] MODE_CLEAR  = 3'd2;
   localparam logic [2:0] MODE_TOGGLE = 3'd3;
   localparam logic [2:0] MODE_PULSE  = 3'd4;

   logic [2:0]            mode;
   logic [IW-1:0]         idx;
   logic                  accept;
   logic                  badReq;
   logic                  doWrite;
   logic                  unusedAddr;
   logic [DATA_WIDTH-1:0] laneMask;
   logic [DATA_WIDTH-1:0] wrBits;
   logic [DATA_WIDTH-1:0] rdData;

   logic [DATA_WIDTH-1:0] value    [NUM_REGS];
   logic [DATA_WIDTH-1:0] mask     [NUM_REGS];
   logic [CW-1:0]         cnt      [NUM_REGS];
   logic [DATA_WIDTH-1:0] valNext  [NUM_REGS];
   logic [DATA_WIDTH-1:0] maskNext [NUM_REGS];
   logic [CW-1:0]         cntNext  [NUM_REGS];

   assign mode       = adr_i[SB+2:SB];
   assign idx        = adr_i[SB+3 +: IW];
   assign unusedAddr = ^adr_i;
   assign rty_o      = 1'b0;

   // A new request is only taken once the previous ack/err pulse has gone away.
   assign accept  = cyc_i & stb_i & ~ack_o & ~err_o;
   assign badReq  = ({1'b0, idx} >= REG_LIMIT) || (mode > MODE_PULSE);
   assign doWrite = accept & ~badReq & we_i;

   always_comb begin
      laneMask = '0;
      for (int i = 0; i < SELECT_WIDTH; i++) begin
         laneMask[i*GW +: GW] = {GW{sel_i[i]}};
      end
   end

   assign wrBits = dat_i & laneMask;

   always_comb begin
      rdData = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (idx == IW'(r)) begin
            rdData = (mode == MODE_PULSE) ? mask[r] : value[r];
         end
      end
   end

   // Pulse expiry is resolved first so a write landing on the expiry edge wins.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         valNext[r]  = value[r];
         maskNext[r] = mask[r];
         cntNext[r]  = cnt[r];
         if (mask[r] != '0) begin
            if (cnt[r] != '0) begin
               cntNext[r] = cnt[r] - CW'(1);
            end else begin
               valNext[r]  = value[r] & ~mask[r];
               maskNext[r] = '0;
            end
         end
         if (doWrite && (idx == IW'(r))) begin
            case (mode)
               MODE_WRITE:  valNext[r] = (valNext[r] & ~laneMask) | wrBits;
               MODE_SET:    valNext[r] = valNext[r] | wrBits;
               MODE_CLEAR:  valNext[r] = valNext[r] & ~wrBits;
               MODE_TOGGLE: valNext[r] = valNext[r] ^ wrBits;
               MODE_PULSE: begin
                  valNext[r]  = valNext[r] | wrBits;
                  maskNext[r] = maskNext[r] | wrBits;
                  cntNext[r]  = CNT_LOAD;
               end
               default: ;
            endcase
         end
      end
   end

   // Reads return the state as it was before the accepting edge.
   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            value[r] <= RESET_PAT;
            mask[r]  <= '0;
            cnt[r]   <= '0;
         end
         ack_o <= 1'b0;
         err_o <= 1'b0;
         dat_o <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            value[r] <= valNext[r];
            mask[r]  <= maskNext[r];
            cnt[r]   <= cntNext[r];
         end
         ack_o <= accept & ~badReq;
         err_o <= accept & badReq;
         if (accept) begin
            if (badReq) begin
               dat_o <= '0;
            end else if (!we_i) begin
               dat_o <= rdData;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : gOut
      assign out[g*DATA_WIDTH +: DATA_WIDTH] = value[g];
   end

endmodule

// File: tb/tb_wb_output_bank.sv
// Self-checking bench for wb_output_bank: directed scenarios plus randomized bus
// traffic compared every cycle against a time-stamped behavioural model.
module tb_wb_output_bank;

   localparam logic [31:0] PAT = 32'hA5A5A5A5;
   localparam int PLEN = 16;

   logic         clk = 1'b0;
   logic         resetN;
   logic         cyc, stb, we;
   logic [31:0]  adr;
   logic [3:0]   sel;
   logic [31:0]  datIn;
   logic [31:0]  datOut;
   logic         ack, err, rty;
   logic [127:0] outBus;

   int nChecks = 0;
   int nErr = 0;
   logic checkEn = 1'b0;

   // Model state: value and pulse mask per register plus the absolute cycle of expiry.
   logic [31:0] mVal [4];
   logic [31:0] mMask [4];
   longint      mExp [4];
   longint      cycle = 0;
   logic        mAck, mErr;
   logic [31:0] mDat;
   logic [2:0]  mMode;
   int          mIdx;
   logic        mAcc, mBad;
   logic [31:0] lm, d;

   wb_output_bank #(
      .DATA_WIDTH(32), .SELECT_WIDTH(4), .NUM_REGS(4), .ADDR_WIDTH(32),
      .RESET_PAT(PAT), .PULSE_LEN(PLEN)
   ) dut (
      .clk_i(clk), .reset_n(resetN), .cyc_i(cyc), .stb_i(stb), .we_i(we),
      .adr_i(adr), .sel_i(sel), .dat_i(datIn), .dat_o(datOut),
      .ack_o(ack), .err_o(err), .rty_o(rty), .out(outBus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] makeAdr(input logic [2:0] mode, input logic [1:0] idx);
      return {25'd0, idx, mode, 2'b00};
   endfunction

   task automatic applyStimulus(input logic wr, input logic [2:0] mode, input logic [1:0] idx,
                                input logic [3:0] selV, input logic [31:0] data,
                                output logic gotAck, output logic gotErr, output logic [31:0] rdata);
      logic done;
      done = 1'b0;
      gotAck = 1'b0;
      gotErr = 1'b0;
      rdata = '0;
      cyc = 1'b1;
      stb = 1'b1;
      we = wr;
      adr = makeAdr(mode, idx);
      sel = selV;
      datIn = data;
      for (int k = 0; k < 6 && !done; k++) begin
         @(negedge clk);
         if (ack || err) begin
            done = 1'b1;
            gotAck = ack;
            gotErr = err;
            rdata = datOut;
         end
      end
      if (!done) begin
         nChecks++;
         nErr++;
         $display("[TB] FAIL bus_timeout: got no ack/err expected response within 6 cycles");
      end
      cyc = 1'b0;
      stb = 1'b0;
   endtask

   // Behavioural model, advanced once per rising edge from the stable inputs.
   initial begin
      forever begin
         @(posedge clk);
         cycle++;
         if (!resetN) begin
            for (int r = 0; r < 4; r++) begin
               mVal[r] = PAT;
               mMask[r] = '0;
            end
            mAck = 1'b0;
            mErr = 1'b0;
            mDat = '0;
         end else begin
            mAcc = cyc && stb && !mAck && !mErr;
            mMode = adr[4:2];
            mIdx = int'(adr[6:5]);
            mBad = (mMode > 3'd4) || (mIdx >= 4);
            if (mAcc) begin
               if (mBad) mDat = '0;
               else if (!we) mDat = (mMode == 3'd4) ? mMask[mIdx] : mVal[mIdx];
            end
            for (int r = 0; r < 4; r++) begin
               if (mMask[r] != 0 && cycle == mExp[r]) begin
                  mVal[r] = mVal[r] & ~mMask[r];
                  mMask[r] = '0;
               end
            end
            if (mAcc && !mBad && we) begin
               lm = '0;
               for (int i = 0; i < 4; i++) if (sel[i]) lm = lm | (32'hFF << (8 * i));
               d = datIn & lm;
               case (mMode)
                  3'd0: mVal[mIdx] = (mVal[mIdx] & ~lm) | d;
                  3'd1: mVal[mIdx] = mVal[mIdx] | d;
                  3'd2: mVal[mIdx] = mVal[mIdx] & ~d;
                  3'd3: mVal[mIdx] = mVal[mIdx] ^ d;
                  default: begin
                     mVal[mIdx] = mVal[mIdx] | d;
                     mMask[mIdx] = mMask[mIdx] | d;
                     mExp[mIdx] = cycle + PLEN;
                  end
               endcase
            end
            mAck = mAcc && !mBad;
            mErr = mAcc && mBad;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (checkEn) begin
            for (int r = 0; r < 4; r++) begin
               checkOutput($sformatf("model_out%0d", r), outBus[r*32 +: 32], mVal[r]);
            end
            checkOutput("model_ack", {31'd0, ack}, {31'd0, mAck});
            checkOutput("model_err", {31'd0, err}, {31'd0, mErr});
            checkOutput("model_dat", datOut, mDat);
            checkOutput("rty", {31'd0, rty}, 32'd0);
         end
      end
   end

   initial begin
      logic        a, e;
      logic [31:0] rd;
      int          hi, both;

      resetN = 1'b0;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = '0; sel = '0; datIn = '0;
      repeat (2) @(negedge clk);
      checkEn = 1'b1;
      for (int r = 0; r < 4; r++) checkOutput($sformatf("reset_out%0d", r), outBus[r*32 +: 32], PAT);
      checkOutput("reset_ack", {31'd0, ack}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);
      checkOutput("reset_dat", datOut, 32'd0);
      resetN = 1'b1;
      @(negedge clk);

      // Lane operations on reg1.
      applyStimulus(1'b1, 3'd0, 2'd1, 4'hF, 32'h12345678, a, e, rd);
      applyStimulus(1'b1, 3'd1, 2'd1, 4'hF, 32'h000000F0, a, e, rd);
      applyStimulus(1'b1, 3'd2, 2'd1, 4'hF, 32'h00000008, a, e, rd);
      applyStimulus(1'b1, 3'd3, 2'd1, 4'hF, 32'hFF000000, a, e, rd);
      checkOutput("reg1_ops", outBus[63:32], 32'hED3456F0);
      applyStimulus(1'b0, 3'd0, 2'd1, 4'hF, 32'h0, a, e, rd);
      checkOutput("reg1_read", rd, 32'hED3456F0);
      checkOutput("reg1_read_ack", {31'd0, a}, 32'd1);

      // Partial lane write on reg2.
      applyStimulus(1'b1, 3'd0, 2'd2, 4'hF, 32'h0, a, e, rd);
      applyStimulus(1'b1, 3'd0, 2'd2, 4'h5, 32'hFFFFFFFF, a, e, rd);
      checkOutput("reg2_lanes", outBus[95:64], 32'h00FF00FF);
      checkOutput("reg0_untouched", outBus[31:0], PAT);
      checkOutput("reg1_untouched", outBus[63:32], 32'hED3456F0);

      // Pulse width on reg0 bit0.
      applyStimulus(1'b1, 3'd0, 2'd0, 4'hF, 32'h0, a, e, rd);
      applyStimulus(1'b1, 3'd4, 2'd0, 4'hF, 32'h1, a, e, rd);
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         if (outBus[0]) hi++;
         @(negedge clk);
      end
      checkOutput("pulse_len", hi, 32'd16);

      applyStimulus(1'b1, 3'd4, 2'd0, 4'hF, 32'h1, a, e, rd);
      applyStimulus(1'b0, 3'd4, 2'd0, 4'hF, 32'h0, a, e, rd);
      checkOutput("mask_during", rd, 32'h1);
      repeat (20) @(negedge clk);
      applyStimulus(1'b0, 3'd4, 2'd0, 4'hF, 32'h0, a, e, rd);
      checkOutput("mask_after", rd, 32'h0);
      checkOutput("reg0_after_pulse", outBus[31:0], 32'h0);

      // Retrigger extends the earlier bit along with the new one.
      applyStimulus(1'b1, 3'd4, 2'd0, 4'hF, 32'h1, a, e, rd);
      repeat (8) @(negedge clk);
      applyStimulus(1'b1, 3'd4, 2'd0, 4'hF, 32'h2, a, e, rd);
      both = 0;
      for (int k = 0; k < 40; k++) begin
         if (outBus[1:0] == 2'b11) both++;
         @(negedge clk);
      end
      checkOutput("retrigger_len", both, 32'd16);
      checkOutput("retrigger_clear", {30'd0, outBus[1:0]}, 32'd0);

      // Error responses.
      applyStimulus(1'b0, 3'd0, 2'd1, 4'hF, 32'h0, a, e, rd);
      applyStimulus(1'b0, 3'd6, 2'd1, 4'hF, 32'h0, a, e, rd);
      checkOutput("err_mode6", {31'd0, e}, 32'd1);
      checkOutput("err_mode6_noack", {31'd0, a}, 32'd0);
      checkOutput("err_mode6_dat", rd, 32'd0);
      applyStimulus(1'b1, 3'd5, 2'd2, 4'hF, 32'h0000FFFF, a, e, rd);
      checkOutput("err_mode5", {31'd0, e}, 32'd1);
      checkOutput("err_nochange", outBus[95:64], 32'h00FF00FF);
      applyStimulus(1'b1, 3'd7, 2'd1, 4'hF, 32'h0, a, e, rd);
      checkOutput("err_mode7_nochange", outBus[63:32], 32'hED3456F0);

      // Set write landing exactly on the pulse expiry edge.
      applyStimulus(1'b1, 3'd0, 2'd3, 4'hF, 32'h0, a, e, rd);
      applyStimulus(1'b1, 3'd4, 2'd3, 4'hF, 32'h1, a, e, rd);
      repeat (15) @(negedge clk);
      applyStimulus(1'b1, 3'd1, 2'd3, 4'hF, 32'h1, a, e, rd);
      checkOutput("expiry_set", outBus[127:96], 32'h1);
      repeat (20) @(negedge clk);
      checkOutput("expiry_set_held", outBus[127:96], 32'h1);
      applyStimulus(1'b0, 3'd4, 2'd3, 4'hF, 32'h0, a, e, rd);
      checkOutput("expiry_mask", rd, 32'h0);

      // Reset on the accepting edge aborts the request.
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = makeAdr(3'd0, 2'd0); sel = 4'hF; datIn = 32'hDEADBEEF;
      resetN = 1'b0;
      @(negedge clk);
      checkOutput("abort_ack", {31'd0, ack}, 32'd0);
      checkOutput("abort_out0", outBus[31:0], PAT);
      checkOutput("abort_out1", outBus[63:32], PAT);
      resetN = 1'b1;
      @(negedge clk);
      checkOutput("after_abort_ack", {31'd0, ack}, 32'd1);
      checkOutput("after_abort_out0", outBus[31:0], 32'hDEADBEEF);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);

      // Randomized traffic including held strobes and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         resetN = ($urandom_range(0, 80) != 0);
         cyc = ($urandom_range(0, 9) != 0);
         stb = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 2) != 0);
         adr = $urandom;
         sel = 4'($urandom);
         datIn = ($urandom_range(0, 1) != 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
         @(negedge clk);
      end
      resetN = 1'b1;
      cyc = 1'b0;
      stb = 1'b0;
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule
